// File: rtl/plic_gateway_arb.sv
// plic_gateway_arb: per-source interrupt gateways (level/edge), a single-target
// priority arbiter and the claim/complete sequencer for one PLIC hart context.
//
// Handshake: claim_i and complete_i are single-cycle strobes with no ready
// side. A claim is taken only when claim_id_o is nonzero in that cycle. A
// complete is taken only when the named source is in flight. Every other
// strobe is dropped and changes no state.
module plic_gateway_arb #(
  parameter int IRQ_NUM   = 32,
  parameter int LEV_WIDTH = 4,
  parameter int GWP_WIDTH = 3,
  parameter int IRQ_WIDTH = $clog2(IRQ_NUM)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [IRQ_NUM-1:0]            irq_i,
  input  logic [IRQ_NUM-1:0]            tm_i,
  input  logic [IRQ_NUM*LEV_WIDTH-1:0]  prio_i,
  input  logic [IRQ_NUM-1:0]            ie_i,
  input  logic [LEV_WIDTH-1:0]          thold_i,
  input  logic                          claim_i,
  input  logic                          complete_i,
  input  logic [IRQ_WIDTH-1:0]          complete_id_i,
  output logic [IRQ_WIDTH-1:0]          claim_id_o,
  output logic [IRQ_NUM-1:0]            ip_o,
  output logic                          irq_o
);

  localparam logic [GWP_WIDTH-1:0] CNT_MAX = '1;

  // Gateway state
  logic [IRQ_NUM-1:0]   r_ip;
  logic [IRQ_NUM-1:0]   r_inflight;
  logic [IRQ_NUM-1:0]   r_prev;
  logic [IRQ_NUM-1:0]   r_tm_q;
  logic [GWP_WIDTH-1:0] r_cnt [IRQ_NUM];

  // Arbiter state
  logic [IRQ_WIDTH-1:0] r_best_id;
  logic [LEV_WIDTH-1:0] r_best_prio;
  logic                 r_irq;

  // Next-state and helper wires
  logic [IRQ_NUM-1:0]   w_ip_n;
  logic [IRQ_NUM-1:0]   w_inflight_n;
  logic [GWP_WIDTH-1:0] w_cnt_n [IRQ_NUM];
  logic [IRQ_NUM-1:0]   w_idle;
  logic [IRQ_NUM-1:0]   w_edge;
  logic [IRQ_NUM-1:0]   w_cnt_nz;
  logic [IRQ_NUM-1:0]   w_consume;
  logic [IRQ_WIDTH-1:0] w_best_id;
  logic [LEV_WIDTH-1:0] w_best_prio;
  logic                 w_claim_fire;

  assign claim_id_o   = r_irq ? r_best_id : '0;
  assign w_claim_fire = claim_i && (claim_id_o != '0);
  assign ip_o         = r_ip;
  assign irq_o        = r_irq;

  assign w_idle    = ~r_ip & ~r_inflight;
  assign w_edge    = irq_i & ~r_prev;
  assign w_consume = w_idle & tm_i & (w_cnt_nz | w_edge);

  // Flag sources that still hold buffered edges
  always_comb begin
    w_cnt_nz = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      w_cnt_nz[i] = (r_cnt[i] != '0);
    end
  end

  // Gateway next state: latch requests, count edges, apply claim/complete
  always_comb begin
    w_ip_n       = r_ip;
    w_inflight_n = r_inflight;
    for (int i = 0; i < IRQ_NUM; i++) begin
      w_cnt_n[i] = r_cnt[i];
      if (tm_i[i]) begin
        // Edge mode: a buffered or fresh edge is promoted when idle. An edge
        // that is consumed in the same cycle never touches the counter.
        if (w_consume[i]) begin
          w_ip_n[i] = 1'b1;
        end
        if (w_edge[i] && !w_consume[i]) begin
          if (r_cnt[i] != CNT_MAX) begin
            w_cnt_n[i] = r_cnt[i] + 1'b1;
          end
        end else if (!w_edge[i] && w_consume[i]) begin
          w_cnt_n[i] = r_cnt[i] - 1'b1;
        end
      end else begin
        if (w_idle[i] && irq_i[i]) begin
          w_ip_n[i] = 1'b1;
        end
        w_cnt_n[i] = '0;
      end
      // Switching trigger mode discards any buffered edges
      if (tm_i[i] != r_tm_q[i]) begin
        w_cnt_n[i] = '0;
      end
      // A claimed source is pending, hence never idle: no set/clear race
      if (w_claim_fire && (claim_id_o == IRQ_WIDTH'(i))) begin
        w_ip_n[i]       = 1'b0;
        w_inflight_n[i] = 1'b1;
      end
      // Completing a source that is not in flight clears an already-clear bit
      if (complete_i && (complete_id_i == IRQ_WIDTH'(i))) begin
        w_inflight_n[i] = 1'b0;
      end
    end
    // Source 0 is reserved and never holds state
    w_ip_n[0]       = 1'b0;
    w_inflight_n[0] = 1'b0;
    w_cnt_n[0]      = '0;
  end

  // Priority search: strict '>' keeps the lowest ID on ties and excludes prio 0
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (r_ip[i] && ie_i[i] &&
          (prio_i[i*LEV_WIDTH +: LEV_WIDTH] > w_best_prio)) begin
        w_best_prio = prio_i[i*LEV_WIDTH +: LEV_WIDTH];
        w_best_id   = IRQ_WIDTH'(i);
      end
    end
  end

  // State registers; a taken claim forces a one-cycle arbiter bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ip        <= '0;
      r_inflight  <= '0;
      r_prev      <= '0;
      r_tm_q      <= '0;
      for (int i = 0; i < IRQ_NUM; i++) begin
        r_cnt[i] <= '0;
      end
      r_best_id   <= '0;
      r_best_prio <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_ip       <= w_ip_n;
      r_inflight <= w_inflight_n;
      r_prev     <= irq_i;
      r_tm_q     <= tm_i;
      for (int i = 0; i < IRQ_NUM; i++) begin
        r_cnt[i] <= w_cnt_n[i];
      end
      if (w_claim_fire) begin
        r_best_id   <= '0;
        r_best_prio <= '0;
        r_irq       <= 1'b0;
      end else begin
        r_best_id   <= w_best_id;
        r_best_prio <= w_best_prio;
        r_irq       <= en_i && (w_best_prio > thold_i);
      end
    end
  end

endmodule

// File: tb/tb_plic_gateway_arb.sv
// Self-checking bench for plic_gateway_arb: expected claim IDs are queued when
// a scenario is set up and popped as each claim is issued.
module tb_plic_gateway_arb;

  localparam int IRQ_NUM   = 32;
  localparam int LEV_WIDTH = 4;
  localparam int GWP_WIDTH = 3;
  localparam int IRQ_WIDTH = 5;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst_i;
  logic                         en_i;
  logic [IRQ_NUM-1:0]           irq_i;
  logic [IRQ_NUM-1:0]           tm_i;
  logic [IRQ_NUM*LEV_WIDTH-1:0] prio_i;
  logic [IRQ_NUM-1:0]           ie_i;
  logic [LEV_WIDTH-1:0]         thold_i;
  logic                         claim_i;
  logic                         complete_i;
  logic [IRQ_WIDTH-1:0]         complete_id_i;
  logic [IRQ_WIDTH-1:0]         claim_id_o;
  logic [IRQ_NUM-1:0]           ip_o;
  logic                         irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IRQ_WIDTH-1:0] exp_q[$];

  plic_gateway_arb #(
    .IRQ_NUM(IRQ_NUM), .LEV_WIDTH(LEV_WIDTH),
    .GWP_WIDTH(GWP_WIDTH), .IRQ_WIDTH(IRQ_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .irq_i(irq_i), .tm_i(tm_i),
    .prio_i(prio_i), .ie_i(ie_i), .thold_i(thold_i), .claim_i(claim_i),
    .complete_i(complete_i), .complete_id_i(complete_id_i),
    .claim_id_o(claim_id_o), .ip_o(ip_o), .irq_o(irq_o)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int src, input logic [LEV_WIDTH-1:0] p);
    prio_i[src*LEV_WIDTH +: LEV_WIDTH] = p;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; irq_i = '0; tm_i = '0; prio_i = '0; ie_i = '0;
    thold_i = '0; claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
    exp_q.delete();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic do_claim(output logic [IRQ_WIDTH-1:0] got);
    claim_i = 1'b1;
    got = claim_id_o;
    tick();
    claim_i = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete_i = 1'b1;
    complete_id_i = IRQ_WIDTH'(id);
    tick();
    complete_i = 1'b0;
    complete_id_i = '0;
  endtask

  task automatic wait_irq(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      if (irq_o === 1'b1) seen = 1'b1;
      else tick();
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    n_checks++; if (ip_o !== '0) begin n_fail++; $display("FAIL reset_ip: got %h expected 0", ip_o); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    n_checks++; if (claim_id_o !== '0) begin n_fail++; $display("FAIL reset_claim_id: got %0d expected 0", claim_id_o); end
  endtask

  task automatic test_level();
    logic [IRQ_WIDTH-1:0] got, exp;
    do_reset();
    en_i = 1'b1; set_prio(3, 4'd5); ie_i[3] = 1'b1;
    tick();
    irq_i[3] = 1'b1;
    tick();
    n_checks++; if (ip_o[3] !== 1'b1) begin n_fail++; $display("FAIL level_ip_t1: got %b expected 1", ip_o[3]); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL level_irq_t1: got %b expected 0", irq_o); end
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL level_irq_t2: got %b expected 1", irq_o); end
    exp_q.push_back(5'd3);
    do_claim(got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL level_claim: got %0d expected %0d", got, exp); end
    n_checks++; if (irq_o !== 1'b0 || ip_o[3] !== 1'b0) begin n_fail++; $display("FAIL level_after_claim: irq %b ip %b expected 0 0", irq_o, ip_o[3]); end
    repeat (3) tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL level_inflight_quiet: got %b expected 0", irq_o); end
    do_complete(3);
    n_checks++; if (ip_o[3] !== 1'b0) begin n_fail++; $display("FAIL level_complete_p0: got %b expected 0", ip_o[3]); end
    tick();
    n_checks++; if (ip_o[3] !== 1'b1 || irq_o !== 1'b0) begin n_fail++; $display("FAIL level_complete_p1: ip %b irq %b expected 1 0", ip_o[3], irq_o); end
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL level_complete_p2: got %b expected 1", irq_o); end
  endtask

  task automatic test_edge();
    logic [IRQ_WIDTH-1:0] got, exp;
    bit seen;
    do_reset();
    en_i = 1'b1; tm_i[7] = 1'b1; set_prio(7, 4'd2); ie_i[7] = 1'b1;
    tick(); tick();
    for (int e = 0; e < 10; e++) begin
      irq_i[7] = 1'b1; tick();
      irq_i[7] = 1'b0; tick();
    end
    for (int n = 0; n < 8; n++) exp_q.push_back(5'd7);
    exp_q.push_back(5'd0);
    for (int n = 0; n < 9; n++) begin
      wait_irq(8, seen);
      n_checks++; if (seen !== (n < 8)) begin n_fail++; $display("FAIL edge_irq_%0d: got %b expected %b", n, seen, (n < 8)); end
      do_claim(got);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL edge_claim_%0d: got %0d expected %0d", n, got, exp); end
      if (got != '0) do_complete(int'(got));
    end
  endtask

  task automatic test_priority();
    logic [IRQ_WIDTH-1:0] got, exp;
    bit seen;
    do_reset();
    en_i = 1'b1;
    set_prio(2, 4'd4); set_prio(9, 4'd6); set_prio(5, 4'd6);
    ie_i[2] = 1'b1; ie_i[9] = 1'b1; ie_i[5] = 1'b1;
    irq_i[2] = 1'b1; irq_i[9] = 1'b1; irq_i[5] = 1'b1;
    exp_q.push_back(5'd5); exp_q.push_back(5'd9); exp_q.push_back(5'd2);
    for (int n = 0; n < 3; n++) begin
      wait_irq(6, seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL prio_wait_%0d: irq_o never rose", n); end
      do_claim(got);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL prio_claim_%0d: got %0d expected %0d", n, got, exp); end
      n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL prio_bubble_%0d: got %b expected 0", n, irq_o); end
      tick();
      n_checks++; if (irq_o !== (n < 2)) begin n_fail++; $display("FAIL prio_resume_%0d: got %b expected %b", n, irq_o, (n < 2)); end
    end
  endtask

  task automatic test_random_prio();
    logic [IRQ_WIDTH-1:0] got, exp;
    logic [IRQ_WIDTH-1:0] ids [3];
    logic [LEV_WIDTH-1:0] prs [3];
    logic [IRQ_WIDTH-1:0] ti;
    logic [LEV_WIDTH-1:0] tp;
    bit seen;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      en_i = 1'b1;
      ids[0] = IRQ_WIDTH'($urandom_range(1, 10));
      ids[1] = IRQ_WIDTH'($urandom_range(11, 20));
      ids[2] = IRQ_WIDTH'($urandom_range(21, 31));
      for (int k = 0; k < 3; k++) begin
        prs[k] = LEV_WIDTH'($urandom_range(1, 15));
        set_prio(int'(ids[k]), prs[k]);
        ie_i[ids[k]] = 1'b1;
        irq_i[ids[k]] = 1'b1;
      end
      // Model: descending priority, ascending ID on ties (stable sort)
      for (int a = 0; a < 2; a++) begin
        for (int j = 0; j < 2 - a; j++) begin
          if (prs[j] < prs[j+1]) begin
            tp = prs[j]; prs[j] = prs[j+1]; prs[j+1] = tp;
            ti = ids[j]; ids[j] = ids[j+1]; ids[j+1] = ti;
          end
        end
      end
      for (int k = 0; k < 3; k++) exp_q.push_back(ids[k]);
      for (int k = 0; k < 3; k++) begin
        wait_irq(6, seen);
        do_claim(got);
        exp = exp_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rand_claim_%0d_%0d: got %0d expected %0d", r, k, got, exp); end
      end
    end
  endtask

  task automatic test_threshold();
    logic [IRQ_WIDTH-1:0] got, exp;
    do_reset();
    en_i = 1'b1; thold_i = 4'd3; set_prio(4, 4'd3); ie_i[4] = 1'b1; irq_i[4] = 1'b1;
    repeat (3) tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL thold_eq_irq: got %b expected 0", irq_o); end
    exp_q.push_back(5'd0);
    do_claim(got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL thold_eq_claim: got %0d expected %0d", got, exp); end
    n_checks++; if (ip_o[4] !== 1'b1) begin n_fail++; $display("FAIL thold_ip_kept: got %b expected 1", ip_o[4]); end
    thold_i = 4'd2;
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL thold_below_irq: got %b expected 1", irq_o); end
    en_i = 1'b0;
    tick();
    n_checks++; if (irq_o !== 1'b0 || ip_o[4] !== 1'b1) begin n_fail++; $display("FAIL en_off: irq %b ip %b expected 0 1", irq_o, ip_o[4]); end
    exp_q.push_back(5'd0);
    do_claim(got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL en_off_claim: got %0d expected %0d", got, exp); end
    en_i = 1'b1;
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL en_on_irq: got %b expected 1", irq_o); end
  endtask

  task automatic test_bad_complete();
    logic [IRQ_WIDTH-1:0] got, exp;
    do_reset();
    en_i = 1'b1; set_prio(6, 4'd1); ie_i[6] = 1'b1; irq_i[6] = 1'b1;
    tick(); tick();
    do_complete(6);
    n_checks++; if (ip_o[6] !== 1'b1 || irq_o !== 1'b1) begin n_fail++; $display("FAIL badc_pending: ip %b irq %b expected 1 1", ip_o[6], irq_o); end
    exp_q.push_back(5'd6);
    do_claim(got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL badc_claim: got %0d expected %0d", got, exp); end
    do_complete(0);
    do_complete(5);
    repeat (3) tick();
    n_checks++; if (ip_o[6] !== 1'b0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL badc_ignored: ip %b irq %b expected 0 0", ip_o[6], irq_o); end
    do_complete(6);
    tick();
    n_checks++; if (ip_o[6] !== 1'b1) begin n_fail++; $display("FAIL badc_good_complete: got %b expected 1", ip_o[6]); end
  endtask

  task automatic test_reset_mid();
    logic [IRQ_WIDTH-1:0] got, exp;
    bit seen;
    do_reset();
    en_i = 1'b1; set_prio(1, 4'd1); ie_i[1] = 1'b1; irq_i[1] = 1'b1;
    tm_i[8] = 1'b1; set_prio(8, 4'd1);
    tick(); tick();
    wait_irq(6, seen);
    exp_q.push_back(5'd1);
    do_claim(got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rstm_claim: got %0d expected %0d", got, exp); end
    for (int e = 0; e < 4; e++) begin
      irq_i[8] = 1'b1; tick();
      irq_i[8] = 1'b0; tick();
    end
    n_checks++; if (ip_o[8] !== 1'b1) begin n_fail++; $display("FAIL rstm_edge_ip: got %b expected 1", ip_o[8]); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++; if (ip_o !== '0 || irq_o !== 1'b0 || claim_id_o !== '0) begin n_fail++; $display("FAIL rstm_outputs: ip %h irq %b id %0d expected 0 0 0", ip_o, irq_o, claim_id_o); end
    tick();
    n_checks++; if (ip_o !== 32'h0000_0002) begin n_fail++; $display("FAIL rstm_repend: got %h expected 00000002", ip_o); end
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL rstm_irq: got %b expected 1", irq_o); end
  endtask

  // Time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_random_prio();
    test_threshold();
    test_bad_complete();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
